// File: rtl/ls_usb_send.sv
// Low-speed USB packet transmitter: SYNC, NRZI-encoded bit-stuffed data and EOP
// at one bit per 8 clk. Optional keep-alive EOP generation is compiled in when
// LS_USB_SEND_KEEPALIVE_EN is defined; without it the keepalive port is ignored.
module ls_usb_send (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_pkt,
  input  logic [7:0] sbyte,
  input  logic       last_byte,
  input  logic       keepalive,
  output logic       byte_taken,
  output logic       dp,
  output logic       dm,
  output logic       bus_oe,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC    = 3'd1,
    S_DATA    = 3'd2,
    S_EOP_SE0 = 3'd3,
    S_EOP_J   = 3'd4
  } state_t;

  state_t     r_state;
  logic [2:0] r_timer;
  logic [2:0] r_bitcnt;
  logic [2:0] r_ones;
  logic [7:0] r_shift;
  logic       r_last;
  logic       r_stuff;
  logic       r_fin;
  logic       r_dp;
  logic       r_dm;
  logic       r_oe;
  logic       r_taken;

  logic       w_bound;
  logic [7:0] w_shift_nx;
  logic [2:0] w_cnt_nx;
  logic       w_last_nx;
  logic       w_fin_nx;
  logic       w_take;
  logic       w_tx_bit;

`ifndef LS_USB_SEND_KEEPALIVE_EN
  logic       w_unused_keepalive;
  assign w_unused_keepalive = keepalive;
`endif

  assign w_bound    = (r_timer == 3'd7);
  assign dp         = r_dp;
  assign dm         = r_dm;
  assign bus_oe     = r_oe;
  assign byte_taken = r_taken;
  assign busy       = (r_state != S_IDLE);

  // Data pointer after the current bit ends, and the bit to put on the line next.
  always_comb begin
    w_shift_nx = r_shift;
    w_cnt_nx   = r_bitcnt;
    w_last_nx  = r_last;
    w_fin_nx   = r_fin;
    w_take     = 1'b0;
    w_tx_bit   = 1'b0;
    if (!r_stuff) begin
      if (r_bitcnt == 3'd7) begin
        if (r_last) begin
          w_fin_nx = 1'b1;
        end else begin
          w_shift_nx = sbyte;
          w_last_nx  = last_byte;
          w_cnt_nx   = 3'd0;
          w_take     = 1'b1;
        end
      end else begin
        w_shift_nx = r_shift >> 1;
        w_cnt_nx   = r_bitcnt + 3'd1;
      end
    end
    if (r_state == S_SYNC) begin
      // SYNC is 0x80: only bit 7 is a one; after it the first data bit follows
      w_tx_bit = (r_bitcnt == 3'd7) ? r_shift[0] : (r_bitcnt == 3'd6);
    end else if (r_ones != 3'd6) begin
      w_tx_bit = w_shift_nx[0];
    end
  end

  // Transmit FSM: bit timing, NRZI line state, stuffing and byte handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_timer  <= 3'd0;
      r_bitcnt <= 3'd0;
      r_ones   <= 3'd0;
      r_shift  <= 8'd0;
      r_last   <= 1'b0;
      r_stuff  <= 1'b0;
      r_fin    <= 1'b0;
      r_dp     <= 1'b0;
      r_dm     <= 1'b1;
      r_oe     <= 1'b0;
      r_taken  <= 1'b0;
    end else begin
      r_taken <= 1'b0;
      r_timer <= (r_state == S_IDLE) ? 3'd0 : r_timer + 3'd1;
      case (r_state)
        S_IDLE: begin
          r_dp <= 1'b0;
          r_dm <= 1'b1;
          r_oe <= 1'b0;
          if (start_pkt) begin
            r_state  <= S_SYNC;
            r_shift  <= sbyte;
            r_last   <= last_byte;
            r_taken  <= 1'b1;
            r_oe     <= 1'b1;
            r_dp     <= 1'b1;
            r_dm     <= 1'b0;
            r_bitcnt <= 3'd0;
            r_ones   <= 3'd0;
            r_stuff  <= 1'b0;
            r_fin    <= 1'b0;
          end
`ifdef LS_USB_SEND_KEEPALIVE_EN
          else if (keepalive) begin
            r_state  <= S_EOP_SE0;
            r_oe     <= 1'b1;
            r_dp     <= 1'b0;
            r_dm     <= 1'b0;
            r_bitcnt <= 3'd0;
          end
`endif
        end
        S_SYNC: begin
          if (w_bound) begin
            if (r_bitcnt == 3'd7) begin
              r_state  <= S_DATA;
              r_bitcnt <= 3'd0;
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (!w_tx_bit) {r_dp, r_dm} <= {r_dm, r_dp};
            r_ones <= w_tx_bit ? r_ones + 3'd1 : 3'd0;
          end
        end
        S_DATA: begin
          if (w_bound) begin
            r_shift  <= w_shift_nx;
            r_bitcnt <= w_cnt_nx;
            r_last   <= w_last_nx;
            r_fin    <= w_fin_nx;
            r_taken  <= w_take;
            if (r_ones == 3'd6) begin
              // stuffed zero: toggle, clear the run, hold the data pointer
              r_stuff        <= 1'b1;
              r_ones         <= 3'd0;
              {r_dp, r_dm}   <= {r_dm, r_dp};
            end else if (w_fin_nx) begin
              r_state  <= S_EOP_SE0;
              r_stuff  <= 1'b0;
              r_bitcnt <= 3'd0;
              r_dp     <= 1'b0;
              r_dm     <= 1'b0;
            end else begin
              r_stuff <= 1'b0;
              if (!w_tx_bit) {r_dp, r_dm} <= {r_dm, r_dp};
              r_ones <= w_tx_bit ? r_ones + 3'd1 : 3'd0;
            end
          end
        end
        S_EOP_SE0: begin
          if (w_bound) begin
            if (r_bitcnt[0]) begin
              r_state <= S_EOP_J;
              r_dp    <= 1'b0;
              r_dm    <= 1'b1;
            end else begin
              r_bitcnt <= 3'd1;
            end
          end
        end
        S_EOP_J: begin
          if (w_bound) begin
            r_state  <= S_IDLE;
            r_oe     <= 1'b0;
            r_bitcnt <= 3'd0;
            r_ones   <= 3'd0;
            r_stuff  <= 1'b0;
            r_fin    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_oe    <= 1'b0;
          r_dp    <= 1'b0;
          r_dm    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ls_usb_send.sv
// Directed bench for ls_usb_send: packets are captured per clk while bus_oe is
// high, compared with an independently encoded line sequence and decoded back
// to bytes by a small NRZI/destuffing receiver.
module tb_ls_usb_send;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_pkt = 1'b0;
  logic [7:0] sbyte = 8'h00;
  logic       last_byte = 1'b0;
  logic       keepalive = 1'b0;
  logic       byte_taken, dp, dm, bus_oe, busy;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] LJ = 2'b01;
  localparam logic [1:0] LK = 2'b10;
  localparam logic [1:0] LSE0 = 2'b00;

  logic [1:0] trace [0:511];
  logic [1:0] expv  [0:511];
  logic [7:0] rx    [0:7];
  int tlen, elen, taken_cnt, rxn;

  always #5 clk = ~clk;

  ls_usb_send dut (
    .clk(clk), .reset(reset), .start_pkt(start_pkt), .sbyte(sbyte),
    .last_byte(last_byte), .keepalive(keepalive), .byte_taken(byte_taken),
    .dp(dp), .dm(dm), .bus_oe(bus_oe), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected per-clk line states: SYNC + stuffed NRZI data, SE0 x16, J x8.
  task automatic build_exp(input logic [7:0] b0, input logic [7:0] b1, input int n);
    int ones = 0;
    logic [1:0] cur = LJ;
    logic bits [$];
    logic [7:0] by;
    bits = {};
    for (int j = 0; j <= n; j++) begin
      by = (j == 0) ? 8'h80 : ((j == 1) ? b0 : b1);
      for (int i = 0; i < 8; i++) begin
        bits.push_back(by[i]);
        if (by[i]) ones++; else ones = 0;
        if (ones == 6) begin
          bits.push_back(1'b0);
          ones = 0;
        end
      end
    end
    elen = 0;
    foreach (bits[k]) begin
      if (!bits[k]) cur = (cur == LJ) ? LK : LJ;
      for (int c = 0; c < 8; c++) begin expv[elen] = cur; elen++; end
    end
    for (int c = 0; c < 16; c++) begin expv[elen] = LSE0; elen++; end
    for (int c = 0; c < 8; c++) begin expv[elen] = LJ; elen++; end
  endtask

  // Send one packet and capture the line while bus_oe is high.
  task automatic run_packet(input logic [7:0] b0, input logic [7:0] b1, input int n,
                            input int glitch_at, input logic ka_with_start);
    int idx = 1;
    tlen = 0;
    taken_cnt = 0;
    @(negedge clk);
    sbyte = b0; last_byte = (n == 1); start_pkt = 1'b1; keepalive = ka_with_start;
    @(negedge clk);
    start_pkt = 1'b0; keepalive = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (byte_taken) begin
        taken_cnt++;
        if (idx < n) begin sbyte = b1; last_byte = 1'b1; idx++; end
      end
      if (!bus_oe) break;
      if (tlen < 512) trace[tlen] = {dp, dm};
      tlen++;
      if (cyc == glitch_at) begin start_pkt = 1'b1; keepalive = 1'b1; end
      else begin start_pkt = 1'b0; keepalive = 1'b0; end
      @(negedge clk);
    end
    start_pkt = 1'b0; keepalive = 1'b0;
  endtask

  task automatic check_packet(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                              input int n, input int exp_oe, input int exp_taken);
    int mism = 0;
    int ones = 1;
    int nb = 0;
    logic [7:0] sync = 8'h00;
    logic [7:0] by = 8'h00;
    logic [1:0] l, prev;
    logic b;
    check({tag, "_oe_len"}, tlen, exp_oe);
    check({tag, "_taken"}, taken_cnt, exp_taken);
    check({tag, "_idle_after"}, {busy, dp, dm, bus_oe}, 4'b0010);
    build_exp(b0, b1, n);
    for (int k = 0; k < tlen && k < elen && k < 512; k++)
      if (trace[k] !== expv[k]) mism++;
    check({tag, "_line_mism"}, mism, 0);
    for (int i = 0; i < 8; i++) sync[i] = (trace[i*8+4] == LK);
    check({tag, "_sync"}, sync, 8'hD5);
    rxn = 0;
    rx[0] = 8'h00; rx[1] = 8'h00;
    prev = trace[60];
    for (int k = 8; k*8+4 < tlen && k*8+4 < 512; k++) begin
      l = trace[k*8+4];
      if (l == LSE0) break;
      b = (l == prev);
      prev = l;
      if (ones == 6) begin
        ones = 0;
      end else begin
        ones = b ? ones + 1 : 0;
        by = {b, by[7:1]};
        nb++;
        if (nb == 8) begin
          if (rxn < 8) rx[rxn] = by;
          rxn++;
          nb = 0;
        end
      end
    end
    check({tag, "_rx_cnt"}, rxn, n);
    check({tag, "_rx_b0"}, rx[0], b0);
    if (n == 2) check({tag, "_rx_b1"}, rx[1], b1);
  endtask

  initial begin
    int oe_cnt, se0_cnt, j_cnt;
    #2 reset = 1'b0;
    #1;
    check("rst_dp", dp, 1'b0);
    check("rst_dm", dm, 1'b1);
    check("rst_oe", bus_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_taken", byte_taken, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // keep-alive request from IDLE
    keepalive = 1'b1;
    @(negedge clk);
    keepalive = 1'b0;
    oe_cnt = 0; se0_cnt = 0; j_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus_oe) begin
        oe_cnt++;
        if ({dp, dm} == LSE0) se0_cnt++;
        if ({dp, dm} == LJ) j_cnt++;
      end
      check("ka_no_taken", byte_taken, 1'b0);
      if (c == 39) break;
      @(negedge clk);
    end
`ifdef LS_USB_SEND_KEEPALIVE_EN
    check("ka_oe", oe_cnt, 24);
    check("ka_se0", se0_cnt, 16);
    check("ka_j", j_cnt, 8);
`else
    check("ka_oe", oe_cnt, 0);
    check("ka_se0", se0_cnt, 0);
    check("ka_j", j_cnt, 0);
`endif
    check("ka_idle", busy, 1'b0);

    run_packet(8'hD2, 8'h00, 1, -1, 1'b0);
    check_packet("d2", 8'hD2, 8'h00, 1, 152, 1);

    run_packet(8'hFF, 8'h00, 1, -1, 1'b0);
    check_packet("ff", 8'hFF, 8'h00, 1, 160, 1);

    run_packet(8'hFF, 8'hFF, 2, -1, 1'b0);
    check_packet("ffff", 8'hFF, 8'hFF, 2, 232, 2);

    run_packet(8'hD2, 8'h00, 1, 40, 1'b0);
    check_packet("restart_ign", 8'hD2, 8'h00, 1, 152, 1);

    run_packet(8'h3C, 8'hA5, 2, -1, 1'b1);
    check_packet("start_wins", 8'h3C, 8'hA5, 2, 216, 2);

    // reset 50 clk into a packet
    @(negedge clk);
    sbyte = 8'hD2; last_byte = 1'b1; start_pkt = 1'b1;
    @(negedge clk);
    start_pkt = 1'b0;
    repeat (49) @(negedge clk);
    check("mid_oe_before", bus_oe, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_dp", dp, 1'b0);
    check("mid_rst_dm", dm, 1'b1);
    check("mid_rst_oe", bus_oe, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_packet(8'hD2, 8'h00, 1, -1, 1'b0);
    check_packet("after_rst", 8'hD2, 8'h00, 1, 152, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
